// File: rtl/systolic_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_feeder_if
//   Bundles the element-write bus, the start/busy/done handshake and the
//   skewed operand streams of systolic_feeder.
//   Ports carried:
//     wr_en, wr_sel, wr_addr[3:0], wr_data[DATA_W-1:0]  element write bus
//     start / busy / done                               run handshake
//     A0..A3, B0..B3 [DATA_W-1:0]                       operand wavefront
//     arr_clr                                           array clear (only when
//                                                       FEEDER_ARRAY_CLR_EN)
//   Modports: master = host side (drives writes/start),
//             slave  = feeder side (systolic_feeder).
//   Optional feature macro: FEEDER_ARRAY_CLR_EN
// ---------------------------------------------------------------------------
interface systolic_feeder_if #(
  parameter int DATA_W = 4
);
  logic              wr_en;
  logic              wr_sel;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] A0, A1, A2, A3;
  logic [DATA_W-1:0] B0, B1, B2, B3;
`ifdef FEEDER_ARRAY_CLR_EN
  logic              arr_clr;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, done, A0, A1, A2, A3, B0, B1, B2, B3, arr_clr
  );
  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, done, A0, A1, A2, A3, B0, B1, B2, B3, arr_clr
  );
`else
  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, done, A0, A1, A2, A3, B0, B1, B2, B3
  );
  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, done, A0, A1, A2, A3, B0, B1, B2, B3
  );
`endif
endinterface

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//   Input-staging stage for a 4x4 systolic array. Holds two 4x4 operand
//   matrices (A and B), written one element at a time while idle. On start it
//   streams the diagonally skewed wavefront (7 beats) into the array, waits
//   DRAIN_CYCLES for the array to settle, then pulses done.
//   Ports:
//     clk    : clock, rising edge
//     reset  : asynchronous active-high reset (clears state, outputs, matrices)
//     bus    : systolic_feeder_if.slave (write bus, start/busy/done, A0..A3,
//              B0..B3, and arr_clr when FEEDER_ARRAY_CLR_EN is defined)
//   Parameters:
//     DATA_W       : operand width
//     DRAIN_CYCLES : wait after the last beat before done (1..15)
//   Optional feature macro: FEEDER_ARRAY_CLR_EN
//     Adds a one-cycle CLEAR state that pulses arr_clr before each wavefront.
// ---------------------------------------------------------------------------
module systolic_feeder #(
  parameter int DATA_W       = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input logic              clk,
  input logic              reset,
  systolic_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BEAT  = 3'd6;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t            state_q, state_d;
  logic [2:0]        t_q, t_d;
  logic [3:0]        drain_q, drain_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] ma_q [4][4];
  logic [DATA_W-1:0] ma_d [4][4];
  logic [DATA_W-1:0] mb_q [4][4];
  logic [DATA_W-1:0] mb_d [4][4];
  logic [DATA_W-1:0] a_q [4];
  logic [DATA_W-1:0] a_d [4];
  logic [DATA_W-1:0] b_q [4];
  logic [DATA_W-1:0] b_d [4];
  logic [DATA_W-1:0] lane_a [4];
  logic [DATA_W-1:0] lane_b [4];
  logic              wr_ok;
`ifdef FEEDER_ARRAY_CLR_EN
  logic              arr_clr_q, arr_clr_d;
`endif

  // -------------------------------------------------------------------------
  // Operand storage. busy_q is the registered busy seen by the host, so a
  // write in the same cycle as an accepted start still lands.
  // -------------------------------------------------------------------------
  assign wr_ok = bus.wr_en && !busy_q;

  always_comb begin
    ma_d = ma_q;
    mb_d = mb_q;
    if (wr_ok) begin
      if (bus.wr_sel)
        mb_d[bus.wr_addr[3:2]][bus.wr_addr[1:0]] = bus.wr_data;
      else
        ma_d[bus.wr_addr[3:2]][bus.wr_addr[1:0]] = bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          ma_q[r][c] <= '0;
          mb_q[r][c] <= '0;
        end
      end
    end else begin
      ma_q <= ma_d;
      mb_q <= mb_d;
    end
  end

  // -------------------------------------------------------------------------
  // Skew: lane i carries ma[i][t-i] and mb[t-i][i] while 0 <= t-i <= 3.
  // The 3-bit difference wraps when t < i; the t >= i test masks that case.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [2:0] off;
    logic       in_window;
    assign off        = t_q - 3'(gi);
    assign in_window  = (t_q >= 3'(gi)) && (off <= 3'd3);
    assign lane_a[gi] = in_window ? ma_q[gi][off[1:0]] : '0;
    assign lane_b[gi] = in_window ? mb_q[off[1:0]][gi] : '0;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      drain_q <= drain_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          t_d = '0;
`ifdef FEEDER_ARRAY_CLR_EN
          state_d = S_CLEAR;
`else
          state_d = S_STREAM;
`endif
        end
      end
      S_CLEAR: begin
        t_d     = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (t_q == LAST_BEAT) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST)
          state_d = S_DONE;
        else
          drain_d = drain_q + 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. Operands and done are registered from the current state,
  // so beat t appears the cycle after the FSM sits on t. busy follows the
  // next state so it rises on the edge that samples start.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
    for (int i = 0; i < 4; i++) begin
      a_d[i] = (state_q == S_STREAM) ? lane_a[i] : '0;
      b_d[i] = (state_q == S_STREAM) ? lane_b[i] : '0;
    end
`ifdef FEEDER_ARRAY_CLR_EN
    arr_clr_d = (state_q == S_CLEAR);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
`ifdef FEEDER_ARRAY_CLR_EN
      arr_clr_q <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      a_q    <= a_d;
      b_q    <= b_d;
`ifdef FEEDER_ARRAY_CLR_EN
      arr_clr_q <= arr_clr_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.A0   = a_q[0];
  assign bus.A1   = a_q[1];
  assign bus.A2   = a_q[2];
  assign bus.A3   = a_q[3];
  assign bus.B0   = b_q[0];
  assign bus.B1   = b_q[1];
  assign bus.B2   = b_q[2];
  assign bus.B3   = b_q[3];
`ifdef FEEDER_ARRAY_CLR_EN
  assign bus.arr_clr = arr_clr_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
//   Self-checking bench for systolic_feeder. Expected wavefront beats are
//   built from a bench-side copy of the matrices when start is driven, queued,
//   and popped as each beat appears on the operand outputs.
// ---------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int DW    = 4;
  localparam int DRAIN = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_feeder_if #(.DATA_W(DW)) sf_if ();

  systolic_feeder #(
    .DATA_W      (DW),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sf_if.slave)
  );

  typedef struct {
    int a[4];
    int b[4];
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    ma_m[4][4];
  int    mb_m[4][4];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int out_a(input int i);
    case (i)
      0:       return int'(sf_if.A0);
      1:       return int'(sf_if.A1);
      2:       return int'(sf_if.A2);
      default: return int'(sf_if.A3);
    endcase
  endfunction

  function automatic int out_b(input int i);
    case (i)
      0:       return int'(sf_if.B0);
      1:       return int'(sf_if.B1);
      2:       return int'(sf_if.B2);
      default: return int'(sf_if.B3);
    endcase
  endfunction

  // Beats 0..6 of the skewed wavefront plus one trailing all-zero beat.
  task automatic push_run();
    for (int t = 0; t < 8; t++) begin
      beat_t e;
      for (int i = 0; i < 4; i++) begin
        int off;
        off    = t - i;
        e.a[i] = (off >= 0 && off <= 3) ? ma_m[i][off] : 0;
        e.b[i] = (off >= 0 && off <= 3) ? mb_m[off][i] : 0;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic write_el(input bit sel, input int addr, input int data);
    sf_if.wr_en   = 1'b1;
    sf_if.wr_sel  = sel;
    sf_if.wr_addr = 4'(addr);
    sf_if.wr_data = DW'(data);
    tick();
    sf_if.wr_en = 1'b0;
    if (sel) mb_m[addr >> 2][addr & 3] = data;
    else     ma_m[addr >> 2][addr & 3] = data;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s A%0d", tag, i), out_a(i), 0);
      check($sformatf("%s B%0d", tag, i), out_b(i), 0);
    end
    check({tag, " busy"}, int'(sf_if.busy), 0);
    check({tag, " done"}, int'(sf_if.done), 0);
  endtask

  // One full multiply: start, 8 beats checked against the queue, drain with
  // done/busy checked every cycle, then one cycle to confirm a single pulse.
  task automatic run(input string tag, input bit lock_wr, input bit drain_start,
                     input bit same_wr);
    if (same_wr) begin
      sf_if.wr_en   = 1'b1;
      sf_if.wr_sel  = 1'b1;
      sf_if.wr_addr = 4'd0;
      sf_if.wr_data = DW'(5);
      mb_m[0][0]    = 5;
    end
    sf_if.start = 1'b1;
    push_run();
    tick();
    sf_if.start = 1'b0;
    sf_if.wr_en = 1'b0;
    check({tag, " busy@E0"}, int'(sf_if.busy), 1);
`ifdef FEEDER_ARRAY_CLR_EN
    check({tag, " arr_clr@E0"}, int'(sf_if.arr_clr), 0);
    tick();
    check({tag, " arr_clr@E1"}, int'(sf_if.arr_clr), 1);
`endif
    for (int t = 0; t < 8; t++) begin
      tick();
`ifdef FEEDER_ARRAY_CLR_EN
      if (t == 0) check({tag, " arr_clr beat0"}, int'(sf_if.arr_clr), 0);
`endif
      if (exp_q.size() == 0) begin
        check({tag, " queue empty"}, 1, 0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
          check($sformatf("%s beat%0d A%0d", tag, t, i), out_a(i), e.a[i]);
          check($sformatf("%s beat%0d B%0d", tag, t, i), out_b(i), e.b[i]);
        end
        $display("%s beat %0d: A=%0d,%0d,%0d,%0d B=%0d,%0d,%0d,%0d", tag, t,
                 out_a(0), out_a(1), out_a(2), out_a(3),
                 out_b(0), out_b(1), out_b(2), out_b(3));
      end
      check($sformatf("%s beat%0d busy", tag, t), int'(sf_if.busy), 1);
      if (lock_wr && t == 2) begin
        sf_if.wr_en   = 1'b1;
        sf_if.wr_sel  = 1'b0;
        sf_if.wr_addr = 4'd0;
        sf_if.wr_data = DW'(9);
      end
      if (lock_wr && t == 3) sf_if.wr_en = 1'b0;
    end
    for (int c = 1; c <= DRAIN; c++) begin
      if (drain_start && c == 2) sf_if.start = 1'b1;
      tick();
      if (drain_start && c == 2) sf_if.start = 1'b0;
      check($sformatf("%s drain%0d done", tag, c), int'(sf_if.done), (c == DRAIN) ? 1 : 0);
      check($sformatf("%s drain%0d busy", tag, c), int'(sf_if.busy), (c == DRAIN) ? 0 : 1);
    end
    tick();
    check({tag, " done pulse end"}, int'(sf_if.done), 0);
    check({tag, " busy idle"}, int'(sf_if.busy), 0);
    $display("%s: run complete", tag);
  endtask

  initial begin
    reset         = 1'b1;
    sf_if.wr_en   = 1'b0;
    sf_if.wr_sel  = 1'b0;
    sf_if.wr_addr = '0;
    sf_if.wr_data = '0;
    sf_if.start   = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma_m[r][c] = 0;
        mb_m[r][c] = 0;
      end

    tick();
    tick();
    check_all_zero("reset");
    $display("reset state checked");
    #3 reset = 1'b0;
    tick();

    // ma[r][c] = r+c+1, mb[k][j] = k+1
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        write_el(1'b0, r * 4 + c, r + c + 1);
        write_el(1'b1, r * 4 + c, r + 1);
      end
    $display("matrices loaded");

    run("run1_lockout", 1'b1, 1'b0, 1'b0);
    run("run2_repeat", 1'b0, 1'b1, 1'b0);
    run("run3_samewr", 1'b0, 1'b0, 1'b1);

    // Reset during beat 2: outputs must clear without waiting for a clock.
    sf_if.start = 1'b1;
    tick();
    sf_if.start = 1'b0;
`ifdef FEEDER_ARRAY_CLR_EN
    tick();
`endif
    tick();
    tick();
    tick();
    check("midrst beat2 A0", out_a(0), ma_m[0][2]);
    check("midrst beat2 B0", out_b(0), mb_m[2][0]);
    reset = 1'b1;
    #1;
    check_all_zero("midrst async");
    $display("mid-operation reset checked");
    #2 reset = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma_m[r][c] = 0;
        mb_m[r][c] = 0;
      end
    tick();
    run("run4_zeros", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
